// File: rtl/global_buffer_sequencer.sv
// Steps global_buffer through one layer pass: load weights, load activations,
// pointer reset, load outputs, pointer reset, read activations back out.
module global_buffer_sequencer #(
    parameter  int depth    = 1024,
    localparam int cntWidth = $clog2(depth + 1)
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                start_i,
    input  logic [cntWidth-1:0] n_weight_i,
    input  logic [cntWidth-1:0] n_act_i,
    input  logic [cntWidth-1:0] n_out_i,
    input  logic [cntWidth-1:0] n_read_i,
    output logic [2:0]          gb_inst_o,
    input  logic                gb_ready_i,
    input  logic                gb_rd_valid_i,
    input  logic                ext_valid_i,
    output logic                ext_ready_o,
    input  logic                obuf_valid_i,
    output logic                obuf_ready_o,
    input  logic                rd_ready_i,
    output logic                rd_valid_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    localparam logic [2:0] I_NOP             = 3'd0;
    localparam logic [2:0] I_LOAD_WEIGHT     = 3'd1;
    localparam logic [2:0] I_LOAD_ACTIVATION = 3'd2;
    localparam logic [2:0] I_LOAD_OUTPUT     = 3'd3;
    localparam logic [2:0] I_POINTER_RESET   = 3'd4;
    localparam logic [2:0] I_READ_ACTIVATION = 3'd5;

    localparam logic [cntWidth-1:0] depthCnt = cntWidth'(depth);

    typedef enum logic [2:0] {
        S_IDLE, S_LDW, S_LDA, S_RST1, S_LDO, S_RST2, S_RD, S_DONE
    } state_t;

    state_t              state, state_next;
    logic [cntWidth-1:0] cnt;
    logic [cntWidth-1:0] n_weight, n_act, n_out, n_read;
    logic [cntWidth-1:0] phase_cnt;
    logic                pend;
    logic                err;
    logic                count_bad;
    logic                beat;
    logic                rd_issue;
    logic                rd_done;
    logic                last_beat;

    // Handshake decode shared by the next-state, output and datapath logic.
    always_comb begin
        count_bad = (n_weight_i > depthCnt) || (n_act_i > depthCnt) ||
                    (n_out_i > depthCnt) || (n_read_i > depthCnt);
        case (state)
            S_LDW:   phase_cnt = n_weight;
            S_LDA:   phase_cnt = n_act;
            S_LDO:   phase_cnt = n_out;
            S_RD:    phase_cnt = n_read;
            default: phase_cnt = '0;
        endcase
        last_beat = (cnt == phase_cnt - 1'b1);
        beat      = (((state == S_LDW) || (state == S_LDA)) && ext_valid_i && gb_ready_i) ||
                    ((state == S_LDO) && obuf_valid_i && gb_ready_i);
        rd_issue  = (state == S_RD) && !pend && rd_ready_i && gb_ready_i;
        rd_done   = (state == S_RD) && pend && gb_rd_valid_i;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= S_IDLE;
        else       state <= state_next;
    end

    // Zero-count phases are skipped by chaining the skip through each transition.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:
                if (start_i && !count_bad) begin
                    if (n_weight_i != '0)   state_next = S_LDW;
                    else if (n_act_i != '0) state_next = S_LDA;
                    else                    state_next = S_RST1;
                end
            S_LDW:
                if (beat && last_beat) state_next = (n_act != '0) ? S_LDA : S_RST1;
            S_LDA:
                if (beat && last_beat) state_next = S_RST1;
            S_RST1:
                state_next = (n_out != '0) ? S_LDO : S_RST2;
            S_LDO:
                if (beat && last_beat) state_next = S_RST2;
            S_RST2:
                state_next = (n_read != '0) ? S_RD : S_DONE;
            S_RD:
                if (rd_done && last_beat) state_next = S_DONE;
            S_DONE:
                state_next = S_IDLE;
            default:
                state_next = S_IDLE;
        endcase
    end

    // The read instruction stays up from issue until the buffer returns data.
    always_comb begin
        gb_inst_o = I_NOP;
        case (state)
            S_LDW:  if (beat) gb_inst_o = I_LOAD_WEIGHT;
            S_LDA:  if (beat) gb_inst_o = I_LOAD_ACTIVATION;
            S_LDO:  if (beat) gb_inst_o = I_LOAD_OUTPUT;
            S_RST1: gb_inst_o = I_POINTER_RESET;
            S_RST2: gb_inst_o = I_POINTER_RESET;
            S_RD:   if (pend || rd_issue) gb_inst_o = I_READ_ACTIVATION;
            default: gb_inst_o = I_NOP;
        endcase
        ext_ready_o  = beat && ((state == S_LDW) || (state == S_LDA));
        obuf_ready_o = beat && (state == S_LDO);
        rd_valid_o   = rd_done;
        busy_o       = (state != S_IDLE) && (state != S_DONE);
        done_o       = (state == S_DONE);
        err_o        = err;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt      <= '0;
            pend     <= 1'b0;
            err      <= 1'b0;
            n_weight <= '0;
            n_act    <= '0;
            n_out    <= '0;
            n_read   <= '0;
        end else begin
            if ((state == S_IDLE) && start_i) begin
                if (count_bad) begin
                    err <= 1'b1;
                end else begin
                    err      <= 1'b0;
                    n_weight <= n_weight_i;
                    n_act    <= n_act_i;
                    n_out    <= n_out_i;
                    n_read   <= n_read_i;
                end
            end
            if (state_next != state)  cnt <= '0;
            else if (beat || rd_done) cnt <= cnt + 1'b1;
            if (rd_done)              pend <= 1'b0;
            else if (rd_issue)        pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_global_buffer_sequencer.sv
// Directed, table-driven bench for global_buffer_sequencer; expected
// instruction/flag values per cycle are written out by hand.
module tb_global_buffer_sequencer;

    localparam int depth    = 1024;
    localparam int cntWidth = $clog2(depth + 1);

    localparam logic [2:0] I_NOP = 3'd0;
    localparam logic [2:0] I_LW  = 3'd1;
    localparam logic [2:0] I_LA  = 3'd2;
    localparam logic [2:0] I_LO  = 3'd3;
    localparam logic [2:0] I_RST = 3'd4;
    localparam logic [2:0] I_RD  = 3'd5;

    // stim  = {start, ext_valid, obuf_valid, gb_ready, rd_ready, gb_rd_valid}
    // flags = {ext_ready, obuf_ready, rd_valid, busy, done, err}
    typedef struct {
        logic [5:0] stim;
        logic [2:0] inst;
        logic [5:0] flags;
    } vec_t;

    logic                clk = 1'b0;
    logic                nrst = 1'b0;
    logic                start_i = 1'b0;
    logic [cntWidth-1:0] n_weight_i = '0;
    logic [cntWidth-1:0] n_act_i = '0;
    logic [cntWidth-1:0] n_out_i = '0;
    logic [cntWidth-1:0] n_read_i = '0;
    logic [2:0]          gb_inst_o;
    logic                gb_ready_i = 1'b0;
    logic                gb_rd_valid_i = 1'b0;
    logic                ext_valid_i = 1'b0;
    logic                ext_ready_o;
    logic                obuf_valid_i = 1'b0;
    logic                obuf_ready_o;
    logic                rd_ready_i = 1'b0;
    logic                rd_valid_o;
    logic                busy_o;
    logic                done_o;
    logic                err_o;

    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];

    int         nA;
    int         beats;
    int         wcnt;
    int         pulses;
    logic       outst;
    logic       sawDone;
    logic       rdy;
    logic       rdv;
    logic       expRv;
    logic       expDone;
    logic [2:0] expInst;

    always #5 clk = ~clk;

    global_buffer_sequencer #(.depth(depth)) dut (
        .clk(clk), .nrst(nrst), .start_i(start_i),
        .n_weight_i(n_weight_i), .n_act_i(n_act_i), .n_out_i(n_out_i), .n_read_i(n_read_i),
        .gb_inst_o(gb_inst_o), .gb_ready_i(gb_ready_i), .gb_rd_valid_i(gb_rd_valid_i),
        .ext_valid_i(ext_valid_i), .ext_ready_o(ext_ready_o),
        .obuf_valid_i(obuf_valid_i), .obuf_ready_o(obuf_ready_o),
        .rd_ready_i(rd_ready_i), .rd_valid_o(rd_valid_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    task automatic setCounts(input int m, input int n, input int o, input int p);
        n_weight_i = cntWidth'(m);
        n_act_i    = cntWidth'(n);
        n_out_i    = cntWidth'(o);
        n_read_i   = cntWidth'(p);
    endtask

    task automatic applyStimulus(input logic [5:0] s);
        {start_i, ext_valid_i, obuf_valid_i, gb_ready_i, rd_ready_i, gb_rd_valid_i} = s;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] inst, input logic [5:0] flags);
        logic [8:0] act;
        logic [8:0] exp;
        act = {gb_inst_o, ext_ready_o, obuf_ready_o, rd_valid_o, busy_o, done_o, err_o};
        exp = {inst, flags};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got inst=%0d flags=%b, expected inst=%0d flags=%b",
                     name, act[8:6], act[5:0], exp[8:6], exp[5:0]);
        end
    endtask

    // One clock: drive just after the rising edge, check on the falling edge.
    task automatic stepCycle(input string name, input logic [5:0] s,
                             input logic [2:0] inst, input logic [5:0] flags);
        applyStimulus(s);
        @(negedge clk);
        checkOutput(name, inst, flags);
        @(posedge clk);
        #1;
    endtask

    task automatic addRow(input logic [5:0] s, input logic [2:0] inst, input logic [5:0] flags);
        vec_t v;
        v.stim  = s;
        v.inst  = inst;
        v.flags = flags;
        tbl.push_back(v);
    endtask

    task automatic runTable(input string name);
        foreach (tbl[i]) stepCycle($sformatf("%s[%0d]", name, i), tbl[i].stim, tbl[i].inst, tbl[i].flags);
        tbl.delete();
    endtask

    initial begin
        applyStimulus(6'b000000);
        #12;
        checkOutput("reset", I_NOP, 6'b000000);
        @(posedge clk);
        #1;
        nrst = 1'b1;

        // Full pass M=2 N=3 O=2 P=2, everything held high; start in S_DONE is ignored.
        setCounts(2, 3, 2, 2);
        addRow(6'b111111, I_NOP, 6'b000000);
        addRow(6'b011111, I_LW,  6'b100100);
        addRow(6'b011111, I_LW,  6'b100100);
        addRow(6'b011111, I_LA,  6'b100100);
        addRow(6'b011111, I_LA,  6'b100100);
        addRow(6'b011111, I_LA,  6'b100100);
        addRow(6'b011111, I_RST, 6'b000100);
        addRow(6'b011111, I_LO,  6'b010100);
        addRow(6'b011111, I_LO,  6'b010100);
        addRow(6'b011111, I_RST, 6'b000100);
        addRow(6'b011111, I_RD,  6'b000100);
        addRow(6'b011111, I_RD,  6'b001100);
        addRow(6'b011111, I_RD,  6'b000100);
        addRow(6'b011111, I_RD,  6'b001100);
        addRow(6'b111111, I_NOP, 6'b000010);
        addRow(6'b011111, I_NOP, 6'b000000);
        runTable("full");

        // M=4 with ext_valid toggling; obuf_valid on idle cycles must not leak through.
        setCounts(4, 0, 0, 0);
        addRow(6'b100100, I_NOP, 6'b000000);
        for (int i = 0; i < 4; i++) begin
            addRow(6'b010100, I_LW,  6'b100100);
            if (i < 3) addRow(6'b001100, I_NOP, 6'b000100);
        end
        addRow(6'b000100, I_RST, 6'b000100);
        addRow(6'b000100, I_RST, 6'b000100);
        addRow(6'b000100, I_NOP, 6'b000010);
        addRow(6'b000100, I_NOP, 6'b000000);
        runTable("toggle");

        // All counts zero: two pointer resets regardless of gb_ready, then done.
        setCounts(0, 0, 0, 0);
        stepCycle("zero_start", 6'b100100, I_NOP, 6'b000000);
        stepCycle("zero_rst1",  6'b000000, I_RST, 6'b000100);
        stepCycle("zero_rst2",  6'b000000, I_RST, 6'b000100);
        stepCycle("zero_done",  6'b000000, I_NOP, 6'b000010);
        stepCycle("zero_idle",  6'b000000, I_NOP, 6'b000000);

        // Oversized count is rejected and sticky until a good start.
        setCounts(0, 0, 0, depth + 1);
        stepCycle("err_start", 6'b100100, I_NOP, 6'b000000);
        stepCycle("err_set",   6'b000100, I_NOP, 6'b000001);
        stepCycle("err_hold",  6'b000100, I_NOP, 6'b000001);
        setCounts(0, 0, 0, 0);
        stepCycle("err_restart", 6'b100100, I_NOP, 6'b000001);
        setCounts(depth + 1, 0, 0, 0);
        stepCycle("err_clear", 6'b000100, I_RST, 6'b000100);
        stepCycle("err_rst2",  6'b000100, I_RST, 6'b000100);
        stepCycle("err_done",  6'b000100, I_NOP, 6'b000010);

        // Count exactly equal to depth is legal and issues depth beats.
        setCounts(0, depth, 0, 0);
        stepCycle("depth_start", 6'b100100, I_NOP, 6'b000000);
        applyStimulus(6'b010100);
        nA = 0;
        sawDone = 1'b0;
        for (int i = 0; i < depth + 100 && !sawDone; i++) begin
            @(negedge clk);
            if (gb_inst_o == I_LA) nA++;
            if (done_o) sawDone = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!sawDone || nA != depth) begin
            failures++;
            $display("[TB] FAIL depth_beats: got %0d beats done=%0d, expected %0d beats done=1", nA, sawDone, depth);
        end

        // P=3 with a three-cycle read latency and rd_ready low for the first two cycles.
        setCounts(0, 0, 0, 3);
        stepCycle("rd_start", 6'b100100, I_NOP, 6'b000000);
        stepCycle("rd_rst1",  6'b000100, I_RST, 6'b000100);
        stepCycle("rd_rst2",  6'b000100, I_RST, 6'b000100);
        outst = 1'b0;
        wcnt = 0;
        beats = 0;
        pulses = 0;
        sawDone = 1'b0;
        for (int k = 0; k < 60 && !sawDone; k++) begin
            rdy = (k >= 2);
            rdv = (outst && wcnt == 3) || (k == 0);
            applyStimulus({3'b000, 1'b1, rdy, rdv});
            @(negedge clk);
            expRv   = outst && wcnt == 3;
            expDone = (beats == 3);
            if (expDone)            expInst = I_NOP;
            else if (outst || rdy)  expInst = I_RD;
            else                    expInst = I_NOP;
            checkOutput($sformatf("rd_k%0d", k), expInst, {2'b00, expRv, !expDone, expDone, 1'b0});
            if (rd_valid_o) pulses++;
            if (expDone) begin
                sawDone = 1'b1;
            end else if (outst && wcnt == 3) begin
                outst = 1'b0;
                beats++;
            end else if (outst) begin
                wcnt++;
            end else if (rdy) begin
                outst = 1'b1;
                wcnt = 1;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!sawDone || pulses != 3) begin
            failures++;
            $display("[TB] FAIL rd_pulses: got %0d pulses done=%0d, expected 3 pulses done=1", pulses, sawDone);
        end

        // Reset asserted mid-activation load, then a fresh pass restarts from S_LDW.
        setCounts(1, 5, 0, 0);
        stepCycle("mid_start", 6'b100100, I_NOP, 6'b000000);
        stepCycle("mid_w",     6'b010100, I_LW,  6'b100100);
        stepCycle("mid_a0",    6'b010100, I_LA,  6'b100100);
        applyStimulus(6'b010100);
        #1;
        checkOutput("mid_a1", I_LA, 6'b100100);
        nrst = 1'b0;
        #1;
        checkOutput("mid_async", I_NOP, 6'b000000);
        @(posedge clk);
        #1;
        checkOutput("mid_held", I_NOP, 6'b000000);
        nrst = 1'b1;
        stepCycle("mid_restart", 6'b110100, I_NOP, 6'b000000);
        stepCycle("mid_rew",     6'b010100, I_LW,  6'b100100);
        stepCycle("mid_rea",     6'b010100, I_LA,  6'b100100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
